// File: rtl/mac_core_if.sv
// mac_core_if: operand-in / result-out handshake bundle for mac_core.
// All lanes share a single valid/ready pair.
interface mac_core_if #(
  parameter int IN_DATA_WIDTH = 8,
  parameter int NUM_LANES     = 4,
  parameter int ACC_WIDTH     = 24
);
  logic                               i_valid;
  logic                               o_ready;
  logic                               i_first;
  logic                               i_last;
  logic                               i_signed;
  logic [NUM_LANES*IN_DATA_WIDTH-1:0] i_a;
  logic [NUM_LANES*IN_DATA_WIDTH-1:0] i_b;
  logic                               o_valid;
  logic                               i_ready;
  logic [NUM_LANES*ACC_WIDTH-1:0]     o_result;
  logic [NUM_LANES-1:0]               o_overflow;

  modport master (
    output i_valid, i_first, i_last, i_signed,
    output i_a, i_b, i_ready,
    input  o_ready, o_valid, o_result, o_overflow
  );

  modport slave (
    input  i_valid, i_first, i_last, i_signed,
    input  i_a, i_b, i_ready,
    output o_ready, o_valid, o_result, o_overflow
  );
endinterface

// File: rtl/mac_core.sv
// mac_core: multi-lane pipelined multiply-accumulate with frame markers.
// Operand register, MUL_STAGES product stages, then accumulate/output.
module mac_core #(
  parameter int IN_DATA_WIDTH = 8,
  parameter int NUM_LANES     = 4,
  parameter int MUL_STAGES    = 2,
  parameter int ACC_WIDTH     = 24
) (
  input logic       clk,
  input logic       reset,
  mac_core_if.slave bus
);
  localparam int W  = IN_DATA_WIDTH;
  localparam int PW = 2 * W;
  localparam int N  = NUM_LANES;
  localparam int S  = MUL_STAGES;
  localparam int AW = ACC_WIDTH;

  logic en;
  assign en = !bus.o_valid || bus.i_ready;
  assign bus.o_ready = en;

  logic         in_v, in_f, in_l, in_s;
  logic [N*W-1:0] in_a, in_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_v <= 1'b0;
      in_f <= 1'b0;
      in_l <= 1'b0;
      in_s <= 1'b0;
      in_a <= '0;
      in_b <= '0;
    end else if (en) begin
      in_v <= bus.i_valid;
      in_f <= bus.i_first;
      in_l <= bus.i_last;
      in_s <= bus.i_signed;
      in_a <= bus.i_a;
      in_b <= bus.i_b;
    end
  end

  // Extending both operands to PW bits lets one multiplier serve both modes
  logic [PW-1:0] ax [N];
  logic [PW-1:0] bx [N];
  logic [PW-1:0] prod [N];

  always_comb begin
    for (int k = 0; k < N; k++) begin
      ax[k] = {{W{in_s & in_a[k*W+W-1]}}, in_a[k*W +: W]};
      bx[k] = {{W{in_s & in_b[k*W+W-1]}}, in_b[k*W +: W]};
      prod[k] = ax[k] * bx[k];
    end
  end

  logic [PW-1:0] pp [S][N];
  logic [S-1:0]  pv, pf, pl, ps;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pv <= '0;
      pf <= '0;
      pl <= '0;
      ps <= '0;
      for (int i = 0; i < S; i++)
        for (int k = 0; k < N; k++)
          pp[i][k] <= '0;
    end else if (en) begin
      pv[0] <= in_v;
      pf[0] <= in_f;
      pl[0] <= in_l;
      ps[0] <= in_s;
      for (int k = 0; k < N; k++)
        pp[0][k] <= prod[k];
      for (int i = 1; i < S; i++) begin
        pv[i] <= pv[i-1];
        pf[i] <= pf[i-1];
        pl[i] <= pl[i-1];
        ps[i] <= ps[i-1];
        for (int k = 0; k < N; k++)
          pp[i][k] <= pp[i-1][k];
      end
    end
  end

  logic v_l, f_l, l_l, s_l;
  assign v_l = pv[S-1];
  assign f_l = pf[S-1];
  assign l_l = pl[S-1];
  assign s_l = ps[S-1];

  logic [AW-1:0] acc [N];
  logic [N-1:0]  ovf_q;
  logic [AW-1:0] ext [N];
  logic [AW-1:0] base [N];
  logic [AW:0]   wide [N];
  logic [AW-1:0] sum [N];
  logic [N-1:0]  step_ovf;
  logic [N-1:0]  sticky_n;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      ext[k] = AW'(pp[S-1][k]);
      if (s_l && pp[S-1][k][PW-1])
        ext[k] = ext[k] | ~AW'({PW{1'b1}});
      base[k] = f_l ? '0 : acc[k];
      wide[k] = {1'b0, base[k]} + {1'b0, ext[k]};
      sum[k]  = wide[k][AW-1:0];
      step_ovf[k] = s_l
        ? (base[k][AW-1] == ext[k][AW-1]) &&
          (sum[k][AW-1] != base[k][AW-1])
        : wide[k][AW];
      sticky_n[k] = (!f_l && ovf_q[k]) | step_ovf[k];
    end
  end

  logic           valid_q;
  logic [N*AW-1:0] res_q;
  logic [N-1:0]    ovf_out_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q   <= 1'b0;
      res_q     <= '0;
      ovf_out_q <= '0;
      ovf_q     <= '0;
      for (int k = 0; k < N; k++)
        acc[k] <= '0;
    end else if (en) begin
      valid_q <= v_l && l_l;
      if (v_l && l_l) begin
        for (int k = 0; k < N; k++) begin
          res_q[k*AW +: AW] <= sum[k];
          acc[k] <= '0;
        end
        ovf_out_q <= sticky_n;
        ovf_q     <= '0;
      end else if (v_l) begin
        for (int k = 0; k < N; k++)
          acc[k] <= sum[k];
        ovf_q <= sticky_n;
      end
    end
  end

  assign bus.o_valid    = valid_q;
  assign bus.o_result   = res_q;
  assign bus.o_overflow = ovf_out_q;
endmodule

// File: tb/tb_mac_core.sv
// tb_mac_core: directed and random checks of mac_core.
// Two instances: default widths and a 16-bit accumulator.
module tb_mac_core;
  localparam int W = 8;
  localparam int N = 4;
  localparam int M = 2;
  localparam int A = 24;
  localparam int A16 = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mac_core_if #(.IN_DATA_WIDTH(W), .NUM_LANES(N), .ACC_WIDTH(A)) bus ();
  mac_core_if #(.IN_DATA_WIDTH(W), .NUM_LANES(N), .ACC_WIDTH(A16)) bus16 ();

  mac_core #(
    .IN_DATA_WIDTH(W), .NUM_LANES(N),
    .MUL_STAGES(M), .ACC_WIDTH(A)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  mac_core #(
    .IN_DATA_WIDTH(W), .NUM_LANES(N),
    .MUL_STAGES(M), .ACC_WIDTH(A16)
  ) dut16 (
    .clk(clk), .reset(reset), .bus(bus16)
  );

  int checks = 0;
  int errors = 0;

  longint m_acc [N];
  bit     m_ovf [N];
  logic [N*A-1:0] eq_res [$];
  logic [N-1:0]   eq_ovf [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic v, f, l, s,
                      input logic [N*W-1:0] a, b);
    bus.i_valid  = v;
    bus.i_first  = f;
    bus.i_last   = l;
    bus.i_signed = s;
    bus.i_a      = a;
    bus.i_b      = b;
  endtask

  // Reference accumulation in plain integer arithmetic
  function automatic void model_beat(input logic f, l, s,
                                     input logic [N*W-1:0] a, b);
    logic [N*A-1:0] er;
    logic [N-1:0]   eo;
    longint mask, half, p, bs, nb, st;
    logic [W-1:0] ak, bk;
    bit ov;
    mask = (longint'(1) << A) - 1;
    half = longint'(1) << (A - 1);
    er = '0;
    eo = '0;
    for (int k = 0; k < N; k++) begin
      ak = a[k*W +: W];
      bk = b[k*W +: W];
      if (s) p = longint'($signed(ak)) * longint'($signed(bk));
      else   p = longint'(ak) * longint'(bk);
      bs = f ? 0 : m_acc[k];
      if (s) begin
        st = (bs >= half) ? bs - (mask + 1) : bs;
        ov = (st + p >= half) || (st + p < -half);
      end else begin
        ov = (bs + p) > mask;
      end
      nb = (bs + p) & mask;
      ov = ov | (f ? 1'b0 : m_ovf[k]);
      if (l) begin
        er[k*A +: A] = nb[A-1:0];
        eo[k] = ov;
        m_acc[k] = 0;
        m_ovf[k] = 1'b0;
      end else begin
        m_acc[k] = nb;
        m_ovf[k] = ov;
      end
    end
    if (l) begin
      eq_res.push_back(er);
      eq_ovf.push_back(eo);
    end
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    beat(0, 0, 0, 0, '0, '0);
    bus.i_ready = 1'b1;
    bus16.i_valid = 1'b0;
    bus16.i_first = 1'b0;
    bus16.i_last = 1'b0;
    bus16.i_signed = 1'b0;
    bus16.i_a = '0;
    bus16.i_b = '0;
    bus16.i_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      m_acc[k] = 0;
      m_ovf[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checks++;
    if (bus.o_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got %b want 0", bus.o_valid);
    end
    checks++;
    if (bus.o_result !== '0) begin
      errors++;
      $display("FAIL reset_result got %h want 0", bus.o_result);
    end
    checks++;
    if (bus.o_overflow !== '0) begin
      errors++;
      $display("FAIL reset_ovf got %b want 0", bus.o_overflow);
    end
    checks++;
    if (bus.o_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b want 1", bus.o_ready);
    end
    tick();
  endtask

  task automatic test_basic();
    logic [N*A-1:0] ev;
    ev = {24'd65025, 24'd100, 24'd14, 24'd15};
    beat(1, 1, 1, 0, {8'd255, 8'd10, 8'd2, 8'd3},
                     {8'd255, 8'd10, 8'd7, 8'd5});
    checks++;
    if (bus.o_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_ready got %b want 1", bus.o_ready);
    end
    tick();
    beat(0, 0, 0, 0, '0, '0);
    for (int c = 1; c <= 3; c++) begin
      tick();
      checks++;
      if (bus.o_valid !== (c == 3)) begin
        errors++;
        $display("FAIL basic_latency cyc %0d got %b want %b",
                 c, bus.o_valid, c == 3);
      end
    end
    checks++;
    if (bus.o_result !== ev) begin
      errors++;
      $display("FAIL basic_result got %h want %h", bus.o_result, ev);
    end
    checks++;
    if (bus.o_overflow !== 4'b0) begin
      errors++;
      $display("FAIL basic_ovf got %b want 0", bus.o_overflow);
    end
    tick();
    checks++;
    if (bus.o_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_single got %b want 0", bus.o_valid);
    end
  endtask

  task automatic test_back_to_back_sign();
    logic [N*A-1:0] e1, e2;
    e1 = {72'd0, 24'hFFFFFE};
    e2 = {72'd0, 24'h0001FE};
    beat(1, 1, 1, 1, 32'h000000FF, 32'h00000002);
    tick();
    beat(1, 1, 1, 0, 32'h000000FF, 32'h00000002);
    tick();
    beat(0, 0, 0, 0, '0, '0);
    tick();
    checks++;
    if (bus.o_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_early got %b want 0", bus.o_valid);
    end
    tick();
    checks++;
    if (bus.o_valid !== 1'b1 || bus.o_result !== e1) begin
      errors++;
      $display("FAIL b2b_signed got %b/%h want 1/%h",
               bus.o_valid, bus.o_result, e1);
    end
    tick();
    checks++;
    if (bus.o_valid !== 1'b1 || bus.o_result !== e2) begin
      errors++;
      $display("FAIL b2b_unsigned got %b/%h want 1/%h",
               bus.o_valid, bus.o_result, e2);
    end
    tick();
    checks++;
    if (bus.o_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_tail got %b want 0", bus.o_valid);
    end
  endtask

  task automatic test_accum();
    int nv;
    logic [N*A-1:0] r;
    for (int i = 0; i < 4; i++) begin
      beat(1, i == 0, i == 3, 0, 32'd10, 32'd10);
      tick();
    end
    beat(0, 0, 0, 0, '0, '0);
    nv = 0;
    r = '0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus.o_valid) begin
        nv++;
        r = bus.o_result;
      end
    end
    checks++;
    if (nv != 1) begin
      errors++;
      $display("FAIL accum_count got %0d want 1", nv);
    end
    checks++;
    if (r !== 96'd400) begin
      errors++;
      $display("FAIL accum_sum got %h want %h", r, 96'd400);
    end
    beat(1, 0, 1, 0, 32'd2, 32'd2);
    tick();
    beat(0, 0, 0, 0, '0, '0);
    nv = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus.o_valid) begin
        nv++;
        r = bus.o_result;
      end
    end
    checks++;
    if (nv != 1 || r !== 96'd4) begin
      errors++;
      $display("FAIL accum_cleared got %0d/%h want 1/%h", nv, r, 96'd4);
    end
  endtask

  task automatic test_backpressure();
    int sent, got, stall;
    logic [N*A-1:0] held, ev;
    sent = 0;
    got = 0;
    stall = 0;
    held = '0;
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      beat(sent < 6, 1, 1, 0, '0, '0);
      bus.i_a[W-1:0] = W'(5 + sent);
      bus.i_b[W-1:0] = W'(5 + sent);
      bus.i_ready = (stall >= 5);
      #3;
      if (bus.o_valid && !bus.i_ready) begin
        checks++;
        if (bus.o_ready !== 1'b0) begin
          errors++;
          $display("FAIL bp_ready got %b want 0", bus.o_ready);
        end
        if (stall == 0) held = bus.o_result;
        else begin
          checks++;
          if (bus.o_result !== held) begin
            errors++;
            $display("FAIL bp_hold got %h want %h", bus.o_result, held);
          end
        end
        stall++;
      end
      if (bus.i_valid && bus.o_ready) sent++;
      if (bus.o_valid && bus.i_ready) begin
        ev = '0;
        ev[A-1:0] = A'((5 + got) * (5 + got));
        checks++;
        if (bus.o_result !== ev) begin
          errors++;
          $display("FAIL bp_order idx %0d got %h want %h",
                   got, bus.o_result, ev);
        end
        got++;
      end
      tick();
    end
    beat(0, 0, 0, 0, '0, '0);
    bus.i_ready = 1'b1;
    checks++;
    if (got != 6) begin
      errors++;
      $display("FAIL bp_count got %0d want 6", got);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (bus.o_valid !== 1'b0) begin
        errors++;
        $display("FAIL bp_dup got %b want 0", bus.o_valid);
      end
    end
  endtask

  task automatic test_acc16();
    int nv;
    logic [N*A16-1:0] r;
    logic [N-1:0] ro;
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < 2; i++) begin
        bus16.i_valid  = 1'b1;
        bus16.i_first  = (i == 0);
        bus16.i_last   = (i == 1);
        bus16.i_signed = (t == 1);
        bus16.i_a = (t == 1) ? {N{8'h80}} : {N{8'hFF}};
        bus16.i_b = (t == 1) ? {N{8'h80}} : {N{8'hFF}};
        tick();
      end
      bus16.i_valid = 1'b0;
      nv = 0;
      r = '0;
      ro = '0;
      for (int c = 0; c < 8; c++) begin
        tick();
        if (bus16.o_valid) begin
          nv++;
          r = bus16.o_result;
          ro = bus16.o_overflow;
        end
      end
      checks++;
      if (nv != 1) begin
        errors++;
        $display("FAIL acc16_count t%0d got %0d want 1", t, nv);
      end
      checks++;
      if (r !== ((t == 1) ? {N{16'h8000}} : {N{16'd64514}})) begin
        errors++;
        $display("FAIL acc16_result t%0d got %h", t, r);
      end
      checks++;
      if (ro !== 4'hF) begin
        errors++;
        $display("FAIL acc16_ovf t%0d got %b want 1111", t, ro);
      end
    end
  endtask

  task automatic test_random();
    logic pend, rf, rl, rs;
    logic [N*W-1:0] ra, rb;
    pend = 1'b0;
    rf = 1'b0;
    rl = 1'b0;
    rs = 1'b0;
    ra = '0;
    rb = '0;
    for (int cyc = 0; cyc < 420; cyc++) begin
      if (cyc < 400) begin
        if (!pend && $urandom_range(0, 3) != 0) begin
          pend = 1'b1;
          rf = ($urandom_range(0, 2) == 0);
          rl = ($urandom_range(0, 2) == 0) || (cyc > 380);
          rs = $urandom_range(0, 1) == 1;
          ra = $urandom;
          rb = $urandom;
        end
        beat(pend, rf, rl, rs, ra, rb);
        bus.i_ready = ($urandom_range(0, 3) != 0);
      end else begin
        beat(0, 0, 0, 0, '0, '0);
        bus.i_ready = 1'b1;
      end
      #3;
      if (bus.i_valid && bus.o_ready) begin
        model_beat(rf, rl, rs, ra, rb);
        pend = 1'b0;
      end
      if (bus.o_valid && bus.i_ready) begin
        checks++;
        if (eq_res.size() == 0) begin
          errors++;
          $display("FAIL rand_extra got %h want none", bus.o_result);
        end else begin
          logic [N*A-1:0] er;
          logic [N-1:0] eo;
          er = eq_res.pop_front();
          eo = eq_ovf.pop_front();
          if (bus.o_result !== er || bus.o_overflow !== eo) begin
            errors++;
            $display("FAIL rand_result got %h/%b want %h/%b",
                     bus.o_result, bus.o_overflow, er, eo);
          end
        end
      end
      tick();
    end
    checks++;
    if (eq_res.size() != 0) begin
      errors++;
      $display("FAIL rand_lost got %0d left want 0", eq_res.size());
    end
  endtask

  task automatic test_reset_flush();
    int nv;
    logic [N*A-1:0] r;
    logic [N-1:0] ro;
    bus.i_ready = 1'b1;
    beat(1, 1, 0, 0, 32'd3, 32'd3);
    tick();
    beat(0, 0, 0, 0, '0, '0);
    repeat (3) tick();
    beat(1, 0, 0, 0, 32'd2, 32'd2);
    tick();
    beat(1, 0, 1, 0, 32'd4, 32'd4);
    tick();
    beat(0, 0, 0, 0, '0, '0);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_result !== '0) begin
      errors++;
      $display("FAIL flush_async got %b/%h want 0/0",
               bus.o_valid, bus.o_result);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    nv = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus.o_valid) nv++;
    end
    checks++;
    if (nv != 0) begin
      errors++;
      $display("FAIL flush_stale got %0d want 0", nv);
    end
    beat(1, 0, 1, 0, 32'd1, 32'd1);
    tick();
    beat(0, 0, 0, 0, '0, '0);
    nv = 0;
    r = '0;
    ro = '1;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus.o_valid) begin
        nv++;
        r = bus.o_result;
        ro = bus.o_overflow;
      end
    end
    checks++;
    if (nv != 1 || r !== 96'd1 || ro !== 4'b0) begin
      errors++;
      $display("FAIL flush_fresh got %0d/%h/%b want 1/%h/0000",
               nv, r, ro, 96'd1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back_sign();
    test_accum();
    test_backpressure();
    test_acc16();
    test_random();
    test_reset_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mac_core.md
Name: mac_core

Overview:
- Parametrised successor to the team's single-lane registered multiplier.
- Multi-lane, pipelined multiply-accumulate core with per-beat signed/unsigned mode and frame-based accumulation (first/last markers).
- Uses a valid/ready handshake on both sides.
- Sits between an operand streamer and a result sink in the accelerator datapath; all lanes share one handshake and advance in lockstep.

Parameters:
- IN_DATA_WIDTH, 8: width of each operand a/b per lane.
- NUM_LANES, 4: number of parallel MAC lanes (>=1).
- MUL_STAGES, 2: register stages in the multiply pipeline (>=1).
- ACC_WIDTH, 24: accumulator/result width per lane (>= 2*IN_DATA_WIDTH).

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_valid  in  1  input beat valid.
- o_ready  out  1  core can accept a beat this cycle.
- i_first  in  1  beat starts a new accumulation (accumulator base = 0).
- i_last  in  1  beat ends the accumulation; result is emitted.
- i_signed  in  1  1 = operands/products two's complement, 0 = unsigned; applies per beat.
- i_a  in  NUM_LANES*IN_DATA_WIDTH  lane k operand at bits [k*IN_DATA_WIDTH +: IN_DATA_WIDTH].
- i_b  in  NUM_LANES*IN_DATA_WIDTH  same packing as i_a.
- o_valid  out  1  result valid.
- i_ready  in  1  sink accepts result this cycle.
- o_result  out  NUM_LANES*ACC_WIDTH  lane k sum at [k*ACC_WIDTH +: ACC_WIDTH].
- o_overflow  out  NUM_LANES  sticky per-lane overflow for the emitted accumulation.

Behaviour:
- Reset (async assert, any time): all stage valid bits, o_valid, o_result, o_overflow, accumulators and overflow-sticky bits go to 0. o_ready reads 1 once reset deasserts. In-flight beats are discarded; there is no partial output.
- Global advance enable: en = !o_valid || i_ready. o_ready = en, a combinational path from i_ready that is permitted. A beat is accepted when i_valid && o_ready.
- When en = 0, every pipeline register, accumulator, o_result and o_overflow holds.
- Pipeline:
  - Stage 1 registers the per-lane product a*b (2*IN_DATA_WIDTH bits, signed or unsigned per i_signed) plus valid/first/last/signed sideband.
  - Stages 2..MUL_STAGES are pure delay of product and sideband.
  - Bubbles (valid = 0) travel through the pipe and do not touch the accumulator.
- Accumulate step, on en when the last-stage valid = 1, per lane:
  - ext = product sign-extended (signed) or zero-extended (unsigned) to ACC_WIDTH.
  - base = first ? 0 : acc.
  - sum = (base + ext) mod 2^ACC_WIDTH.
- Overflow of that add:
  - unsigned: carry out of bit ACC_WIDTH-1.
  - signed: base and ext have the same sign and sum's sign differs.
  - ovf_sticky = (first ? 0 : ovf_sticky) | step_overflow.
- If last = 0: acc <= sum; no output.
- If last = 1: o_result <= sum, o_overflow <= new sticky, o_valid <= 1; acc and ovf_sticky cleared to 0. A following beat without i_first therefore still starts from 0.
- first and last on the same beat produces a single product result, matching the legacy multiplier's behaviour.
- o_valid control: on en, o_valid <= (last-stage valid && last). o_valid is cleared by a handshake (o_valid && i_ready) unless a new result loads in the same cycle, which is back-to-back and allowed.
- Latency: a beat accepted at edge T with last = 1 gives o_valid = 1 after edge T+MUL_STAGES+1, with no stalls. Throughput is 1 beat/cycle while i_ready = 1.
- Mixed i_signed within one accumulation is legal; each step uses its own beat's mode for extension and overflow.
- No beat is dropped or duplicated under any i_valid/i_ready pattern.

Test Plan:
- Defaults, reset then lane0 a=3, b=5, unsigned, first=last=1 -> o_valid 3 cycles after acceptance, lane0 o_result=15, o_overflow=0, other lanes = product of their operands.
- a=8'hFF, b=8'h02, first=last=1: signed -> 24'hFFFFFE; unsigned -> 24'h0001FE.
- 4 beats lane0 10*10, first on beat 0, last on beat 3, consecutive cycles -> exactly one o_valid, result 400 (0x190); then a beat with first=0, last=1, 2*2 -> 4, confirming the accumulator cleared.
- Backpressure: i_ready=0 while o_valid=1 -> o_result stable, o_ready=0, offered beats not accepted. i_ready released after 5 cycles -> all results delivered in order, none lost or duplicated. Also run random i_valid/i_ready against a reference model.
- ACC_WIDTH=16: unsigned 255*255 twice (first, then last) -> result 64514, o_overflow=1. Signed -128*-128 twice -> 16'h8000, o_overflow=1.
- Reset asserted with 2 beats in the pipe and a partial accumulation -> o_valid=0 immediately. No result from pre-reset beats. A post-reset first=0, last=1 beat 1*1 -> result 1.
